mem_port_arbiter: RTL and testbench

// - Shares one single-port synchronous block RAM between the two cpu_core memory requesters:

---
 rtl/rv_mem_pkg.sv | 18 +
 rtl/rr_arb2.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the I/D memory port arbiter: owner encoding and the
// response tag carried alongside every issued BRAM access.
package rv_mem_pkg;

    localparam logic OWN_I   = 1'b0;
    localparam logic OWN_D   = 1'b1;
    localparam int   WSTRB_W = 4;

    typedef struct packed {
        logic valid;
        logic owner;
        logic is_write;
    } rsp_tag_t;

    localparam int       TAG_W     = $bits(rsp_tag_t);
    localparam rsp_tag_t TAG_EMPTY = '{valid: 1'b0, owner: OWN_I, is_write: 1'b0};

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; prio_r names the requester that wins the next tie
// and only moves when a grant is actually given.
module rr_arb2
    import rv_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic [1:0] grant_s;
    logic       prio_r;

    // grant selection; nothing is granted while reset is held
    always_comb begin
        grant_s = 2'b00;
        if (rst) begin
            grant_s = 2'b00;
        end else if (req[OWN_I] && (!req[OWN_D] || prio_r == OWN_I)) begin
            grant_s[OWN_I] = 1'b1;
        end else if (req[OWN_D]) begin
            grant_s[OWN_D] = 1'b1;
        end else begin
            grant_s = 2'b00;
        end
    end

    // priority pointer hands the next tie to whoever was not just served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_r <= OWN_I;
        end else if (grant_s[OWN_I]) begin
            prio_r <= OWN_D;
        end else if (grant_s[OWN_D]) begin
            prio_r <= OWN_I;
        end else begin
            prio_r <= prio_r;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port BRAM between the fetch (I) and load/store (D) ports:
// zero-latency round-robin issue plus an in-order tag pipeline that routes responses.
module mem_port_arbiter
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_AW  = 12,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic               i_ready,
    output logic               i_rvalid,
    output logic [DATA_W-1:0]  i_rdata,
    input  logic               d_req,
    input  logic [WSTRB_W-1:0] d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [DATA_W-1:0]  d_wdata,
    output logic               d_ready,
    output logic               d_rvalid,
    output logic [DATA_W-1:0]  d_rdata,
    output logic               mem_en,
    output logic [WSTRB_W-1:0] mem_we,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               busy
);

    logic [1:0]             grant_s;
    rsp_tag_t               new_tag_s;
    rsp_tag_t               out_tag_s;
    rsp_tag_t [MEM_LAT-1:0] tag_r;
    logic                   unused_addr_s;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .req   ({d_req, i_req}),
        .grant (grant_s)
    );

    assign i_ready = grant_s[OWN_I];
    assign d_ready = grant_s[OWN_D];

    // Byte offset and bits above the BRAM window are dropped, so addresses wrap.
    assign unused_addr_s = ^{i_addr[ADDR_W-1:MEM_AW+2], i_addr[1:0],
                             d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};

    // issue mux: granted port drives the BRAM directly and builds its response tag
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = {WSTRB_W{1'b0}};
        mem_addr  = {MEM_AW{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        new_tag_s = TAG_EMPTY;
        if (grant_s[OWN_D]) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr[MEM_AW+1:2];
            mem_wdata = d_wdata;
            new_tag_s = '{valid: 1'b1, owner: OWN_D, is_write: (d_we != {WSTRB_W{1'b0}})};
        end else if (grant_s[OWN_I]) begin
            mem_en    = 1'b1;
            mem_addr  = i_addr[MEM_AW+1:2];
            new_tag_s = '{valid: 1'b1, owner: OWN_I, is_write: 1'b0};
        end else begin
            mem_en    = 1'b0;
        end
    end

    // tag shift register aligned with the BRAM read latency; reset drops in-flight tags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_r <= {MEM_LAT{TAG_EMPTY}};
        end else begin
            tag_r[0] <= new_tag_s;
            for (int k = 1; k < MEM_LAT; k++) begin
                tag_r[k] <= tag_r[k-1];
            end
        end
    end

    // response routing from the last tag stage; write acks return zero data
    always_comb begin
        out_tag_s = tag_r[MEM_LAT-1];
        busy      = 1'b0;
        for (int k = 0; k < MEM_LAT; k++) begin
            busy = busy | tag_r[k].valid;
        end
        i_rvalid = out_tag_s.valid & (out_tag_s.owner == OWN_I);
        d_rvalid = out_tag_s.valid & (out_tag_s.owner == OWN_D);
        if (i_rvalid) begin
            i_rdata = mem_rdata;
        end else begin
            i_rdata = {DATA_W{1'b0}};
        end
        if (d_rvalid && !out_tag_s.is_write) begin
            d_rdata = mem_rdata;
        end else begin
            d_rdata = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four instances (MEM_LAT 1..4) share stimulus, each with
// its own BRAM model; a request-level reference model predicts grants and responses.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_we;

    logic [3:0]  i_ready_a, i_rvalid_a, d_ready_a, d_rvalid_a, mem_en_a, busy_a;
    logic [31:0] i_rdata_a [4];
    logic [31:0] d_rdata_a [4];
    logic [31:0] mem_wdata_a [4];
    logic [3:0]  mem_we_a [4];
    logic [11:0] mem_addr_a [4];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        prio = 1'b0;
    logic        last_gi = 1'b0;
    logic        last_gd = 1'b0;
    int          wr_idx = 0;
    int          rd_idx [4];
    logic        exp_own [4096];
    logic [31:0] exp_dat [4096];
    int          exp_cyc [4096];
    logic [31:0] ref_mem [4096];

    function automatic logic [31:0] init_word(input logic [11:0] w);
        if (w == 12'd4) return 32'hDEADBEEF;
        else if (w == 12'd2) return 32'h11223344;
        else return {4'h5, w, 4'hA, ~w};
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] base, input logic [31:0] wd,
                                                input logic [3:0] we);
        logic [31:0] r;
        r = base;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[13:2] = 12'($urandom_range(0, 15));
        return a;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_lat
        logic [31:0]   bram [4096];
        logic [4095:0] bram_wr = '0;
        logic [31:0]   rpipe [4];
        logic [31:0]   cur;

        assign cur = bram_wr[mem_addr_a[g]] ? bram[mem_addr_a[g]] : init_word(mem_addr_a[g]);

        // read-first BRAM with a fixed-latency output pipe
        always @(posedge clk) begin
            if (mem_en_a[g]) begin
                rpipe[0] <= cur;
                if (mem_we_a[g] != 4'b0000) begin
                    bram[mem_addr_a[g]]    <= merge_bytes(cur, mem_wdata_a[g], mem_we_a[g]);
                    bram_wr[mem_addr_a[g]] <= 1'b1;
                end
            end
            for (int k = 1; k < 4; k++) rpipe[k] <= rpipe[k-1];
        end

        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_AW(12), .MEM_LAT(g + 1)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .i_req     (i_req),
            .i_addr    (i_addr),
            .i_ready   (i_ready_a[g]),
            .i_rvalid  (i_rvalid_a[g]),
            .i_rdata   (i_rdata_a[g]),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_ready   (d_ready_a[g]),
            .d_rvalid  (d_rvalid_a[g]),
            .d_rdata   (d_rdata_a[g]),
            .mem_en    (mem_en_a[g]),
            .mem_we    (mem_we_a[g]),
            .mem_addr  (mem_addr_a[g]),
            .mem_wdata (mem_wdata_a[g]),
            .mem_rdata (rpipe[g]),
            .busy      (busy_a[g])
        );
    end

    task automatic push(input logic own, input logic [31:0] dat);
        exp_own[wr_idx] = own;
        exp_dat[wr_idx] = dat;
        exp_cyc[wr_idx] = cyc;
        if (wr_idx < 4095) wr_idx++;
    endtask

    // Reference model + scoreboard, evaluated mid-cycle (negedge).
    task automatic monitor();
        logic        gi, gd, ev_i, ev_d, eb;
        logic [31:0] ed;
        logic [11:0] ea;
        if (rst) begin
            for (int g = 0; g < 4; g++) begin
                checks++;
                if (|{i_ready_a[g], i_rvalid_a[g], i_rdata_a[g], d_ready_a[g], d_rvalid_a[g],
                      d_rdata_a[g], mem_en_a[g], mem_we_a[g], mem_addr_a[g], mem_wdata_a[g],
                      busy_a[g]} !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_hold lat=%0d got nonzero output, required all 0", g + 1);
                end
                rd_idx[g] = wr_idx;
            end
            prio = 1'b0;
            last_gi = 1'b0;
            last_gd = 1'b0;
        end else begin
            gi = i_req && (!d_req || !prio);
            gd = d_req && !gi;
            ea = gi ? 12'((i_addr >> 2) % 32'd4096) : 12'((d_addr >> 2) % 32'd4096);
            for (int g = 0; g < 4; g++) begin
                if (i_req || d_req) begin
                    checks++;
                    if ({i_ready_a[g], d_ready_a[g], mem_en_a[g]} !== {gi, gd, 1'b1}) begin
                        errors++;
                        $display("FAIL grant lat=%0d got=%b required=%b cyc=%0d", g + 1,
                                 {i_ready_a[g], d_ready_a[g], mem_en_a[g]}, {gi, gd, 1'b1}, cyc);
                    end
                    checks++;
                    if (mem_addr_a[g] !== ea) begin
                        errors++;
                        $display("FAIL issue_addr lat=%0d got=%h required=%h", g + 1, mem_addr_a[g], ea);
                    end
                    checks++;
                    if (mem_we_a[g] !== (gd ? d_we : 4'b0000)) begin
                        errors++;
                        $display("FAIL issue_we lat=%0d got=%b required=%b", g + 1, mem_we_a[g],
                                 gd ? d_we : 4'b0000);
                    end
                    if (gd) begin
                        checks++;
                        if (mem_wdata_a[g] !== d_wdata) begin
                            errors++;
                            $display("FAIL issue_wdata lat=%0d got=%h required=%h", g + 1,
                                     mem_wdata_a[g], d_wdata);
                        end
                    end
                end
                eb = rd_idx[g] < wr_idx;
                ev_i = 1'b0;
                ev_d = 1'b0;
                ed = 32'h0;
                if (eb && exp_cyc[rd_idx[g]] + g + 1 == cyc) begin
                    ev_i = !exp_own[rd_idx[g]];
                    ev_d = exp_own[rd_idx[g]];
                    ed   = exp_dat[rd_idx[g]];
                    rd_idx[g]++;
                end
                if (eb || i_rvalid_a[g] || d_rvalid_a[g] || busy_a[g]) begin
                    checks++;
                    if ({i_rvalid_a[g], d_rvalid_a[g], busy_a[g]} !== {ev_i, ev_d, eb}) begin
                        errors++;
                        $display("FAIL rsp_valid lat=%0d got ivdvb=%b required=%b cyc=%0d", g + 1,
                                 {i_rvalid_a[g], d_rvalid_a[g], busy_a[g]}, {ev_i, ev_d, eb}, cyc);
                    end
                end
                if (ev_i) begin
                    checks++;
                    if (i_rdata_a[g] !== ed) begin
                        errors++;
                        $display("FAIL i_rdata lat=%0d got=%h required=%h", g + 1, i_rdata_a[g], ed);
                    end
                end
                if (ev_d) begin
                    checks++;
                    if (d_rdata_a[g] !== ed) begin
                        errors++;
                        $display("FAIL d_rdata lat=%0d got=%h required=%h", g + 1, d_rdata_a[g], ed);
                    end
                end
            end
            if (gi) begin
                push(1'b0, ref_mem[ea]);
            end else if (gd && d_we != 4'b0000) begin
                ref_mem[ea] = merge_bytes(ref_mem[ea], d_wdata, d_we);
                push(1'b1, 32'h0);
            end else if (gd) begin
                push(1'b1, ref_mem[ea]);
            end
            if (gi) prio = 1'b1;
            else if (gd) prio = 1'b0;
            last_gi = gi;
            last_gd = gd;
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (|{i_ready_a[g], i_rvalid_a[g], i_rdata_a[g], d_ready_a[g], d_rvalid_a[g],
                  d_rdata_a[g], mem_en_a[g], mem_we_a[g], mem_addr_a[g], mem_wdata_a[g],
                  busy_a[g]} !== 1'b0) begin
                errors++;
                $display("FAIL reset_initial lat=%0d got nonzero output, required all 0", g + 1);
            end
        end
        tick();
        tick();
        rst = 1'b0;
        d_req = 1'b1;
        d_we = 4'b0000;
        d_addr = 32'h10;
        #1;
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (d_ready_a[g] !== 1'b1) begin
                errors++;
                $display("FAIL pre_reset_ready lat=%0d got=%b required=1", g + 1, d_ready_a[g]);
            end
        end
        tick();
        i_req = 1'b1;
        d_addr = 32'h20;
        #1;
        checks++;
        if (busy_a[1] !== 1'b1) begin
            errors++;
            $display("FAIL busy_inflight got=%b required=1", busy_a[1]);
        end
        rst = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (|{i_ready_a[g], i_rvalid_a[g], i_rdata_a[g], d_ready_a[g], d_rvalid_a[g],
                  d_rdata_a[g], mem_en_a[g], mem_we_a[g], mem_addr_a[g], mem_wdata_a[g],
                  busy_a[g]} !== 1'b0) begin
                errors++;
                $display("FAIL reset_async lat=%0d got nonzero output, required all 0", g + 1);
            end
        end
        tick();
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            for (int g = 0; g < 4; g++) begin
                checks++;
                if ({i_rvalid_a[g], d_rvalid_a[g], busy_a[g]} !== 3'b000) begin
                    errors++;
                    $display("FAIL post_reset_quiet lat=%0d got=%b required=000", g + 1,
                             {i_rvalid_a[g], d_rvalid_a[g], busy_a[g]});
                end
            end
            tick();
        end
    endtask

    task automatic test_single_fetch();
        i_req = 1'b1;
        i_addr = 32'h0000_0010;
        #1;
        for (int g = 0; g < 4; g++) begin
            checks++;
            if ({i_ready_a[g], mem_addr_a[g]} !== {1'b1, 12'd4}) begin
                errors++;
                $display("FAIL fetch_issue lat=%0d got ready=%b addr=%h required ready=1 addr=004",
                         g + 1, i_ready_a[g], mem_addr_a[g]);
            end
        end
        tick();
        i_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            for (int g = 0; g < 4; g++) begin
                checks++;
                if (i_rvalid_a[g] !== (c == g + 1)) begin
                    errors++;
                    $display("FAIL fetch_latency lat=%0d cycle=%0d got=%b", g + 1, c, i_rvalid_a[g]);
                end
                if (c == g + 1) begin
                    checks++;
                    if (i_rdata_a[g] !== 32'hDEADBEEF) begin
                        errors++;
                        $display("FAIL fetch_data lat=%0d got=%h required=deadbeef", g + 1, i_rdata_a[g]);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_contention();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_req = 1'b1;
        d_req = 1'b1;
        d_we = 4'b0000;
        i_addr = rand_addr();
        d_addr = rand_addr();
        for (int k = 0; k < 6; k++) begin
            #1;
            for (int g = 0; g < 4; g++) begin
                checks++;
                if ({i_ready_a[g], d_ready_a[g]} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL contention_order lat=%0d slot=%0d got=%b", g + 1, k,
                             {i_ready_a[g], d_ready_a[g]});
                end
            end
            tick();
            if (k % 2 == 0) i_addr = rand_addr();
            else d_addr = rand_addr();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_byte_store();
        d_req = 1'b1;
        d_we = 4'b0010;
        d_addr = 32'h8;
        d_wdata = 32'h0000AB00;
        #1;
        for (int g = 0; g < 4; g++) begin
            checks++;
            if ({d_ready_a[g], mem_we_a[g], mem_addr_a[g]} !== {1'b1, 4'b0010, 12'd2}) begin
                errors++;
                $display("FAIL store_issue lat=%0d got rdy=%b we=%b addr=%h", g + 1,
                         d_ready_a[g], mem_we_a[g], mem_addr_a[g]);
            end
        end
        tick();
        d_we = 4'b0000;
        #1;
        checks++;
        if ({d_rvalid_a[0], d_rdata_a[0]} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL store_ack got v=%b d=%h required v=1 d=00000000", d_rvalid_a[0], d_rdata_a[0]);
        end
        tick();
        d_req = 1'b0;
        #1;
        checks++;
        if ({d_rvalid_a[0], d_rdata_a[0]} !== {1'b1, 32'h1122AB44}) begin
            errors++;
            $display("FAIL load_after_store got v=%b d=%h required v=1 d=1122ab44",
                     d_rvalid_a[0], d_rdata_a[0]);
        end
        repeat (5) tick();
    endtask

    task automatic test_addr_wrap();
        d_req = 1'b1;
        d_we = 4'b0000;
        d_addr = 32'h0000_4004;
        #1;
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (mem_addr_a[g] !== 12'd1) begin
                errors++;
                $display("FAIL addr_wrap lat=%0d got=%h required=001", g + 1, mem_addr_a[g]);
            end
        end
        tick();
        d_req = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_latency_sweep();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!i_req || last_gi) begin
                i_req = ($urandom_range(0, 3) != 0);
                i_addr = rand_addr();
            end
            if (!d_req || last_gd) begin
                d_req = ($urandom_range(0, 3) != 0);
                d_addr = rand_addr();
                d_we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                d_wdata = $urandom;
            end
            tick();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (6) tick();
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (rd_idx[g] !== wr_idx) begin
                errors++;
                $display("FAIL lost_responses lat=%0d got delivered=%0d required=%0d", g + 1,
                         rd_idx[g], wr_idx);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        i_addr = 32'h0;
        d_addr = 32'h0;
        d_wdata = 32'h0;
        d_we = 4'b0000;
        for (int g = 0; g < 4; g++) rd_idx[g] = 0;
        for (int w = 0; w < 4096; w++) ref_mem[w] = init_word(12'(w));
        test_reset();
        test_single_fetch();
        test_contention();
        test_byte_store();
        test_addr_wrap();
        test_latency_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
